// File: rtl/decode_in_pkg.sv
// Shared types for the queued LC3 decode-input transaction driver.
// Bus widths, the buffered transaction record and the issue FSM state encoding.
package decode_in_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam int GAP_W   = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    npc;
        logic [GAP_W-1:0]   gap;
    } decode_in_txn_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } decode_in_drv_state_t;

endpackage

// File: rtl/decode_in_txn_driver_if.sv
// Push port plus decode-input bus of decode_in_txn_driver.
// The slave modport is the driver itself; the master modport is the sequencer side.
interface decode_in_txn_driver_if
    import decode_in_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                         push_valid;
    logic                         push_ready;
    logic [INSTR_W-1:0]           push_instr;
    logic [PC_W-1:0]              push_npc;
    logic [GAP_W-1:0]             push_gap;
    logic                         stall;
    logic                         flush;
    logic [INSTR_W-1:0]           Instr_dout;
    logic [PC_W-1:0]              npc_in;
    logic                         enable_decode;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         idle;

    modport slave (
        input  push_valid, push_instr, push_npc, push_gap, stall, flush,
        output push_ready, Instr_dout, npc_in, enable_decode, count, idle
    );

    modport master (
        output push_valid, push_instr, push_npc, push_gap, stall, flush,
        input  push_ready, Instr_dout, npc_in, enable_decode, count, idle
    );
endinterface

// File: rtl/decode_in_txn_fifo.sv
// Synchronous FIFO of decode transactions with flush; full/empty derive from the occupancy count.
// Pointers wrap naturally at DEPTH (power of two).
module decode_in_txn_fifo
    import decode_in_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  decode_in_txn_t             i_din,
    output decode_in_txn_t             o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    decode_in_txn_t   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // pointer and occupancy update; flush wins over push and pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // storage array, data only
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/decode_in_txn_driver.sv
// Queued LC3 decode-input driver: buffers pushed transactions and replays them with stall/gap/flush.
// Optional macro DECODE_IN_NPC_AUTO_EN replaces the stored NPC by an internal auto-incrementing PC.
module decode_in_txn_driver
    import decode_in_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef DECODE_IN_NPC_AUTO_EN
    , parameter logic [PC_W-1:0] RESET_PC = 16'h3000
`endif
) (
    input  logic                   clock,
    input  logic                   reset_n,
    decode_in_txn_driver_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    decode_in_drv_state_t r_state;
    decode_in_drv_state_t w_state_nx;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [GAP_W-1:0]     w_gap_nx;
    logic [GAP_W-1:0]     r_cur_gap;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_npc;
    logic                 r_en;
    decode_in_txn_t       w_din;
    decode_in_txn_t       w_head;
    decode_in_txn_t       w_load_txn;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_push_acc;
    logic                 w_take;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_load;

    assign w_push_acc = bus.push_valid && !w_full && !bus.flush;

    // incoming transaction record
    always_comb begin
        w_din.instr = bus.push_instr;
        w_din.gap   = bus.push_gap;
`ifdef DECODE_IN_NPC_AUTO_EN
        w_din.npc   = '0;
`else
        w_din.npc   = bus.push_npc;
`endif
    end

    decode_in_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push_acc && !w_bypass),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // issue FSM: decide whether the issue slot frees up, then fill it from the queue or a fresh push
    always_comb begin
        w_state_nx = r_state;
        w_gap_nx   = r_gap_cnt;
        w_take     = 1'b0;
        case (r_state)
            IDLE: w_take = 1'b1;
            DRIVE: begin
                if (!bus.stall) begin
                    if (r_cur_gap != GAP_W'(0)) begin
                        w_state_nx = GAP;
                        w_gap_nx   = r_cur_gap;
                    end else begin
                        w_take = 1'b1;
                    end
                end else begin
                    w_state_nx = DRIVE;
                end
            end
            GAP: begin
                w_gap_nx = r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt == GAP_W'(1)) w_take = 1'b1;
                else                        w_state_nx = GAP;
            end
            default: w_state_nx = IDLE;
        endcase

        w_pop      = 1'b0;
        w_bypass   = 1'b0;
        w_load     = 1'b0;
        w_load_txn = w_head;
        if (bus.flush) begin
            w_state_nx = IDLE;
            w_gap_nx   = '0;
        end else if (w_take) begin
            // an empty queue lets an accepted push go straight onto the bus
            if (!w_empty) begin
                w_pop      = 1'b1;
                w_load     = 1'b1;
                w_state_nx = DRIVE;
            end else if (w_push_acc) begin
                w_bypass   = 1'b1;
                w_load     = 1'b1;
                w_load_txn = w_din;
                w_state_nx = DRIVE;
            end else begin
                w_state_nx = IDLE;
            end
        end else begin
            w_load_txn = w_head;
        end
    end

`ifdef DECODE_IN_NPC_AUTO_EN
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nx;

    assign w_pc_nx = (r_state == DRIVE && !bus.stall) ? r_pc + PC_W'(1) : r_pc;

    // auto PC advances on every completed issue and survives flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_pc <= RESET_PC;
        else          r_pc <= w_pc_nx;
    end
`endif

    // state and registered decode bus
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_cur_gap <= '0;
            r_instr   <= '0;
            r_en      <= 1'b0;
`ifdef DECODE_IN_NPC_AUTO_EN
            r_npc     <= RESET_PC;
`else
            r_npc     <= '0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_gap_cnt <= w_gap_nx;
            r_en      <= (w_state_nx == DRIVE);
            if (w_load) begin
                r_instr   <= w_load_txn.instr;
                r_cur_gap <= w_load_txn.gap;
`ifdef DECODE_IN_NPC_AUTO_EN
                r_npc     <= w_pc_nx;
`else
                r_npc     <= w_load_txn.npc;
`endif
            end
        end
    end

    assign bus.push_ready    = !w_full;
    assign bus.Instr_dout    = r_instr;
    assign bus.npc_in        = r_npc;
    assign bus.enable_decode = r_en;
    assign bus.count         = w_count;
    assign bus.idle          = w_empty && (r_state == IDLE);
endmodule

// File: tb/tb_decode_in_txn_driver.sv
// Bench for decode_in_txn_driver (default build): directed vector table, hand sequences for
// fill/flush/reset, then random traffic against a queue-based reference model.
module tb_decode_in_txn_driver;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    decode_in_txn_driver_if #(.DEPTH(DEPTH)) bus ();

    decode_in_txn_driver #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] npc;
        logic [3:0]  gap;
    } txn_t;

    typedef struct {
        logic        pv;
        logic [15:0] instr;
        logic [15:0] npc;
        logic [3:0]  gap;
        logic        stall;
        logic        flush;
        logic        e_en;
        logic [15:0] e_instr;
        logic [15:0] e_npc;
        int          e_count;
        logic        e_idle;
    } vec_t;

    // reference model: queue of waiting transactions, the one on the bus, and idle cycles owed
    txn_t        mq[$];
    logic        m_en;
    logic [15:0] m_instr;
    logic [15:0] m_npc;
    int          m_cur_gap;
    int          m_low;

    task automatic model_reset();
        mq.delete();
        m_en = 1'b0; m_instr = 16'h0; m_npc = 16'h0; m_cur_gap = 0; m_low = 0;
    endtask

    task automatic model_load(input txn_t t);
        m_en = 1'b1; m_instr = t.instr; m_npc = t.npc; m_cur_gap = int'(t.gap);
    endtask

    task automatic model_step(input logic pv, input txn_t t, input logic st, input logic fl);
        int  sz;
        bit  acc;
        bit  take;
        sz   = mq.size();
        acc  = pv && (sz < DEPTH);
        take = 1'b0;
        if (fl) begin
            mq.delete();
            m_en  = 1'b0;
            m_low = 0;
            return;
        end
        if (m_en) begin
            if (!st) begin
                if (m_cur_gap > 0) begin m_en = 1'b0; m_low = m_cur_gap; end
                else take = 1'b1;
            end
        end else if (m_low > 0) begin
            if (m_low == 1) begin m_low = 0; take = 1'b1; end
            else m_low = m_low - 1;
        end else begin
            take = 1'b1;
        end
        if (take) begin
            if (sz > 0) model_load(mq.pop_front());
            else if (acc) begin model_load(t); acc = 1'b0; end
            else m_en = 1'b0;
        end
        if (acc) mq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".en"},    32'(bus.enable_decode), 32'(m_en));
        chk({tag, ".instr"}, 32'(bus.Instr_dout),    32'(m_instr));
        chk({tag, ".npc"},   32'(bus.npc_in),        32'(m_npc));
        chk({tag, ".count"}, 32'(bus.count),         32'(mq.size()));
        chk({tag, ".idle"},  32'(bus.idle),          32'(mq.size() == 0 && !m_en && m_low == 0));
        chk({tag, ".ready"}, 32'(bus.push_ready),    32'(mq.size() < DEPTH));
    endtask

    // drive one cycle of inputs, let the edge pass, advance the model, then sample #1 later
    task automatic tick(input logic pv, input logic [15:0] ins, input logic [15:0] npc,
                        input logic [3:0] gp, input logic st, input logic fl);
        txn_t t;
        t.instr = ins; t.npc = npc; t.gap = gp;
        bus.push_valid = pv; bus.push_instr = ins; bus.push_npc = npc; bus.push_gap = gp;
        bus.stall = st; bus.flush = fl;
        @(posedge clock);
        model_step(pv, t, st, fl);
        #1;
    endtask

    vec_t vt[17];
    int   seen;
    logic [15:0] got[$];

    initial begin
        bus.push_valid = 1'b0; bus.push_instr = 16'h0; bus.push_npc = 16'h0;
        bus.push_gap = 4'h0; bus.stall = 1'b0; bus.flush = 1'b0;
        model_reset();

        // pv instr npc gap stall flush | en instr npc count idle
        vt[0]  = '{1'b1, 16'h1234, 16'h3001, 4'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3001, 0, 1'b0};
        vt[1]  = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h3001, 0, 1'b1};
        vt[2]  = '{1'b1, 16'h1111, 16'h0A01, 4'd0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0A01, 0, 1'b0};
        vt[3]  = '{1'b1, 16'h2222, 16'h0B02, 4'd0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0B02, 0, 1'b0};
        vt[4]  = '{1'b1, 16'h3333, 16'h0C03, 4'd0, 1'b0, 1'b0, 1'b1, 16'h3333, 16'h0C03, 0, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h0C03, 0, 1'b1};
        vt[6]  = '{1'b1, 16'h4444, 16'h0D04, 4'd3, 1'b0, 1'b0, 1'b1, 16'h4444, 16'h0D04, 0, 1'b0};
        vt[7]  = '{1'b1, 16'h5555, 16'h0E05, 4'd0, 1'b0, 1'b0, 1'b0, 16'h4444, 16'h0D04, 1, 1'b0};
        vt[8]  = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h4444, 16'h0D04, 1, 1'b0};
        vt[9]  = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 16'h4444, 16'h0D04, 1, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0E05, 0, 1'b0};
        vt[11] = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0E05, 0, 1'b1};
        vt[12] = '{1'b1, 16'h6666, 16'h0F06, 4'd0, 1'b0, 1'b0, 1'b1, 16'h6666, 16'h0F06, 0, 1'b0};
        vt[13] = '{1'b1, 16'h7777, 16'h1007, 4'd0, 1'b1, 1'b0, 1'b1, 16'h6666, 16'h0F06, 1, 1'b0};
        vt[14] = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 16'h6666, 16'h0F06, 1, 1'b0};
        vt[15] = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h1007, 0, 1'b0};
        vt[16] = '{1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h1007, 0, 1'b1};

        #12;
        chk("rst.en",    32'(bus.enable_decode), 32'h0);
        chk("rst.instr", 32'(bus.Instr_dout),    32'h0);
        chk("rst.npc",   32'(bus.npc_in),        32'h0);
        chk("rst.count", 32'(bus.count),         32'h0);
        chk("rst.idle",  32'(bus.idle),          32'h1);
        chk("rst.ready", 32'(bus.push_ready),    32'h1);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            tick(vt[i].pv, vt[i].instr, vt[i].npc, vt[i].gap, vt[i].stall, vt[i].flush);
            chk($sformatf("vec%0d.en", i),    32'(bus.enable_decode), 32'(vt[i].e_en));
            chk($sformatf("vec%0d.instr", i), 32'(bus.Instr_dout),    32'(vt[i].e_instr));
            chk($sformatf("vec%0d.npc", i),   32'(bus.npc_in),        32'(vt[i].e_npc));
            chk($sformatf("vec%0d.count", i), 32'(bus.count),         32'(vt[i].e_count));
            chk($sformatf("vec%0d.idle", i),  32'(bus.idle),          32'(vt[i].e_idle));
        end

        // fill under stall: one on the bus plus DEPTH queued; the last offer is refused
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 16'h5000 + 16'(i), 16'h0100 + 16'(i), 4'd0, 1'b1, 1'b0);
            check_model($sformatf("fill%0d", i));
        end
        chk("fill.count", 32'(bus.count),      32'(DEPTH));
        chk("fill.ready", 32'(bus.push_ready), 32'h0);
        chk("fill.head",  32'(bus.Instr_dout), 32'h5000);
        got.delete();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
            check_model($sformatf("drain%0d", i));
            if (bus.enable_decode) got.push_back(bus.Instr_dout);
        end
        seen = got.size();
        chk("drain.n", 32'(seen), 32'd8);
        for (int i = 0; i < seen && i < 8; i++)
            chk($sformatf("drain.ord%0d", i), 32'(got[i]), 32'(16'h5001 + 16'(i)));

        // flush with five queued; the push offered in the flush cycle is dropped
        for (int i = 0; i < 6; i++) tick(1'b1, 16'h6000 + 16'(i), 16'h0200, 4'd0, 1'b1, 1'b0);
        chk("flq.count", 32'(bus.count), 32'd5);
        tick(1'b1, 16'h6FFF, 16'h0FFF, 4'd0, 1'b0, 1'b1);
        chk("fl.count", 32'(bus.count),         32'h0);
        chk("fl.en",    32'(bus.enable_decode), 32'h0);
        chk("fl.idle",  32'(bus.idle),          32'h1);
        chk("fl.hold",  32'(bus.Instr_dout),    32'h6000);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
            chk($sformatf("flpost%0d.en", i), 32'(bus.enable_decode), 32'h0);
        end

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [3:0] g;
            g = ($urandom % 8 < 5) ? 4'd0 : 4'($urandom_range(1, 3));
            tick(1'($urandom % 2), 16'($urandom), 16'($urandom), g,
                 1'($urandom % 4 == 0), 1'($urandom % 32 == 0));
            check_model($sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of a stalled drive
        for (int i = 0; i < 4; i++) tick(1'b1, 16'h7A00 + 16'(i), 16'h0300, 4'd2, 1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        chk("mrst.en",    32'(bus.enable_decode), 32'h0);
        chk("mrst.instr", 32'(bus.Instr_dout),    32'h0);
        chk("mrst.count", 32'(bus.count),         32'h0);
        chk("mrst.idle",  32'(bus.idle),          32'h1);
        model_reset();
        reset_n = 1'b1;
        tick(1'b1, 16'hBEEF, 16'h3005, 4'd0, 1'b0, 1'b0);
        check_model("post_rst");
        tick(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        check_model("post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
